// File: rtl/arr_scan_pkg.sv
// ============================================================================
// Module   : arr_scan_pkg
// Brief    : Shared types and constants for the arr_scan_out slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arr_scan_pkg;

    typedef logic [3:0] arr_t;
    typedef logic [1:0] sel_t;

    localparam int NUM_ARR = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/arr_scan_timer.sv
// ============================================================================
// Module   : arr_scan_timer
// Brief    : Hold counter plus slot counter; flags slot advance and frame end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arr_scan_timer
    import arr_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic slot_adv,
    output logic frame_end,
    output sel_t sel
);

    localparam int                  c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    logic [c_HOLD_W-1:0] r_hold;
    sel_t                r_sel;
    logic                w_wrap;

    assign w_wrap    = enable && (r_hold == c_HOLD_LAST);
    assign slot_adv  = w_wrap && (r_sel != 2'd3);
    assign frame_end = w_wrap && (r_sel == 2'd3);
    assign sel       = r_sel;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_hold <= '0;
            r_sel  <= '0;
        end else if (w_wrap) begin
            r_hold <= '0;
            r_sel  <= r_sel + 2'd1;
        end else if (enable) begin
            r_hold <= r_hold + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/arr_scan_out.sv
// ============================================================================
// Module   : arr_scan_out
// Brief    : Snapshots arr0..arr3 per frame and time-multiplexes them onto a
//            4-bit bus with slot select, strobe and frame-start markers.
//            Optional macro ARR_SCAN_SKIP_UNCHANGED_EN skips unchanged frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arr_scan_out
    import arr_scan_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             arr0,
    input  logic [3:0]             arr1,
    input  logic [3:0]             arr2,
    input  logic [3:0]             arr3,
    input  logic                   ext_hold,
    output logic [3:0]             scan_data,
    output logic [1:0]             scan_sel,
    output logic                   scan_strobe,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [1:0] c_ST_IDLE = S_IDLE;
    localparam logic [1:0] c_ST_SCAN = S_SCAN;

    logic [1:0]             r_state;
    arr_t                   r_snap [NUM_ARR];
    arr_t                   r_scan_data;
    sel_t                   r_scan_sel;
    logic                   r_scan_strobe;
    logic                   r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic w_timer_en;
    logic w_slot_adv;
    logic w_frame_end;
    sel_t w_t_sel;
    sel_t w_next_sel;
    logic w_capture;
    logic w_skip;

    // Timer only runs while scanning so it sits at zero in IDLE/WAIT.
    assign w_timer_en = ~ext_hold & (r_state == c_ST_SCAN);
    assign w_next_sel = w_t_sel + 2'd1;

`ifdef ARR_SCAN_SKIP_UNCHANGED_EN
    localparam logic [1:0] c_ST_WAIT = S_WAIT;

    logic r_snap_valid;
    logic w_same;

    assign w_same = r_snap_valid &&
                    (arr0 == r_snap[0]) && (arr1 == r_snap[1]) &&
                    (arr2 == r_snap[2]) && (arr3 == r_snap[3]);
    assign w_skip    = w_frame_end & w_same;
    assign w_capture = ((r_state == c_ST_IDLE) && !ext_hold) ||
                       (w_frame_end && !w_same) ||
                       ((r_state == c_ST_WAIT) && !ext_hold && !w_same);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_valid <= 1'b0;
        end else if (w_capture) begin
            r_snap_valid <= 1'b1;
        end
    end
`else
    assign w_skip    = 1'b0;
    assign w_capture = ((r_state == c_ST_IDLE) && !ext_hold) || w_frame_end;
`endif

    arr_scan_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (w_timer_en),
        .restart   (w_capture),
        .slot_adv  (w_slot_adv),
        .frame_end (w_frame_end),
        .sel       (w_t_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_scan_data   <= '0;
            r_scan_sel    <= '0;
            r_scan_strobe <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
            for (int i = 0; i < NUM_ARR; i++) r_snap[i] <= '0;
        end else begin
            r_scan_strobe <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_capture) begin
                r_snap[0]     <= arr0;
                r_snap[1]     <= arr1;
                r_snap[2]     <= arr2;
                r_snap[3]     <= arr3;
                r_scan_data   <= arr0;
                r_scan_sel    <= '0;
                r_scan_strobe <= 1'b1;
                r_frame_start <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + FRAME_CNT_W'(1);
                r_state       <= c_ST_SCAN;
`ifdef ARR_SCAN_SKIP_UNCHANGED_EN
            end else if (w_skip) begin
                r_state <= c_ST_WAIT;
`endif
            end else if (w_slot_adv) begin
                r_scan_sel    <= w_next_sel;
                r_scan_data   <= r_snap[w_next_sel];
                r_scan_strobe <= 1'b1;
            end
        end
    end

`ifndef ARR_SCAN_SKIP_UNCHANGED_EN
    logic w_unused;
    assign w_unused = w_skip;
`endif

    assign scan_data   = r_scan_data;
    assign scan_sel    = r_scan_sel;
    assign scan_strobe = r_scan_strobe;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_arr_scan_out.sv
// ============================================================================
// Module   : tb_arr_scan_out
// Brief    : Directed self-checking bench for arr_scan_out (HOLD_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arr_scan_out;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] arr0, arr1, arr2, arr3;
    logic       ext_hold;
    logic [3:0] scan_data;
    logic [1:0] scan_sel;
    logic       scan_strobe;
    logic       frame_start;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    arr_scan_out #(
        .HOLD_CYCLES (4),
        .FRAME_CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arr0        (arr0),
        .arr1        (arr1),
        .arr2        (arr2),
        .arr3        (arr3),
        .ext_hold    (ext_hold),
        .scan_data   (scan_data),
        .scan_sel    (scan_sel),
        .scan_strobe (scan_strobe),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [1:0] s,
                           input logic st, input logic fs, input logic [7:0] fc);
        chk({tag, ".data"},   scan_data,   d);
        chk({tag, ".sel"},    scan_sel,    s);
        chk({tag, ".strobe"}, scan_strobe, st);
        chk({tag, ".fstart"}, frame_start, fs);
        chk({tag, ".fcnt"},   frame_cnt,   fc);
    endtask

    initial begin
        reset = 1'b1; ext_hold = 1'b0;
        arr0 = 4'd1; arr1 = 4'd2; arr2 = 4'd3; arr3 = 4'd4;
        step(); step();
        chk_out("reset", 4'd0, 2'd0, 1'b0, 1'b0, 8'd0);

        // Frame 1: capture on the first edge after release (cycle c=0).
        reset = 1'b0;
        step();
        chk_out("f1_c0", 4'd1, 2'd0, 1'b1, 1'b1, 8'd1);
        for (int c = 1; c < 16; c++) begin
            step();
            chk_out($sformatf("f1_c%0d", c), 4'(c / 4 + 1), 2'(c / 4),
                    (c % 4) == 0, 1'b0, 8'd1);
            if (c == 8) arr1 = 4'hF;
        end

        // Frame 2 captures at c=16 and sees the new arr1.
        step();
        chk_out("f2_c16", 4'd1, 2'd0, 1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) step();
        chk_out("f2_slot1", 4'hF, 2'd1, 1'b1, 1'b0, 8'd2);

        // ext_hold on the 2nd cycle of slot 1 for three edges.
        step();
        chk("c21.strobe", scan_strobe, 1'b0);
        ext_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("held_%0d", i), 4'hF, 2'd1, 1'b0, 1'b0, 8'd2);
        end
        ext_hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out($sformatf("post_hold_%0d", i), 4'hF, 2'd1, 1'b0, 1'b0, 8'd2);
        end
        step();
        chk_out("c27_slot2", 4'd3, 2'd2, 1'b1, 1'b0, 8'd2);

        // Advance to the last cycle of slot 3 (c=34), then hold across capture.
        for (int i = 0; i < 7; i++) step();
        chk_out("c34_slot3", 4'd4, 2'd3, 1'b0, 1'b0, 8'd2);
        ext_hold = 1'b1; arr0 = 4'd7;
        step();
        chk_out("cap_held0", 4'd4, 2'd3, 1'b0, 1'b0, 8'd2);
        step();
        chk_out("cap_held1", 4'd4, 2'd3, 1'b0, 1'b0, 8'd2);
        ext_hold = 1'b0; arr0 = 4'd8;
        step();
        chk_out("cap_release", 4'd8, 2'd0, 1'b1, 1'b1, 8'd3);

        // Reset in slot 2 of frame 3.
        for (int i = 0; i < 8; i++) step();
        chk_out("f3_slot2", 4'd3, 2'd2, 1'b1, 1'b0, 8'd3);
        reset = 1'b1;
        step();
        chk_out("mid_reset", 4'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        step();
        chk_out("post_reset", 4'd8, 2'd0, 1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 15; i++) step();
        chk_out("pr_last", 4'd4, 2'd3, 1'b0, 1'b0, 8'd1);
        step();
`ifdef ARR_SCAN_SKIP_UNCHANGED_EN
        chk_out("skip_wait0", 4'd4, 2'd3, 1'b0, 1'b0, 8'd1);
        for (int i = 0; i < 5; i++) step();
        chk_out("skip_wait5", 4'd4, 2'd3, 1'b0, 1'b0, 8'd1);
        arr3 = 4'd5;
        step();
        chk_out("skip_recap", 4'd8, 2'd0, 1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 12; i++) step();
        chk_out("skip_slot3", 4'd5, 2'd3, 1'b1, 1'b0, 8'd2);
`else
        chk_out("recap", 4'd8, 2'd0, 1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 12; i++) step();
        chk_out("recap_slot3", 4'd4, 2'd3, 1'b1, 1'b0, 8'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/arr_scan_out.md
Name: arr_scan_out

Overview:
- Sits between the pipeline_proc core outputs (arr0..arr3, 4 bits each) and a reduced output pad set.
- Atomically snapshots all four arrays at a frame boundary, then time-multiplexes them onto one 4-bit bus.
- Each slot carries a select code and a strobe, so off-chip logic can rebuild a coherent frame with 7 pads instead of 16.

Parameters:
- HOLD_CYCLES, 4: clock cycles each slot is held on scan_data. Legal range is 1 or more.
- FRAME_CNT_W, 8: width of the frame counter.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- arr0  input  4  core array 0
- arr1  input  4  core array 1
- arr2  input  4  core array 2
- arr3  input  4  core array 3
- ext_hold  input  1  freeze request, already synchronised upstream
- scan_data  output  4  snapshot word for the current slot
- scan_sel  output  2  slot index 0..3
- scan_strobe  output  1  one-cycle pulse on the first cycle of each slot
- frame_start  output  1  one-cycle pulse on the first cycle of slot 0
- frame_cnt  output  FRAME_CNT_W  count of captured frames

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: scan_data=0, scan_sel=0, scan_strobe=0, frame_start=0, frame_cnt=0, snapshot=0, snap_valid=0, state=S_IDLE.
- Reset asserted mid-frame: all of the above are restored on the next edge. The partial frame is abandoned with no further strobes.
- States: S_IDLE, S_SCAN, and S_WAIT (S_WAIT only when the optional feature is compiled in).
- Capture edge:
  - Occurs on the first edge with reset low and ext_hold low while in S_IDLE.
  - Also occurs on the edge after the last cycle of slot 3.
  - Actions: snapshot<=arr0..3, scan_data<=arr0, scan_sel<=0, scan_strobe<=1, frame_start<=1, frame_cnt<=frame_cnt+1, snap_valid<=1, state<=S_SCAN.
- Latency: arrN sampled at capture edge E. Slot 0 data is visible from E until E+HOLD_CYCLES. Slot k is visible from E+k*HOLD_CYCLES.
- Frame timing: period is exactly 4*HOLD_CYCLES cycles, with no gap between frames.
- Within a slot: hold counter runs 0..HOLD_CYCLES-1. On wrap, scan_sel increments, scan_data<=snapshot[scan_sel+1], and scan_strobe pulses.
- Pulse width: scan_strobe and frame_start are high for exactly one cycle each.
- HOLD_CYCLES=1: scan_strobe is high every cycle, and scan_sel steps every cycle.
- Input stability: arr changes between capture edges have no effect on the current frame.
- frame_cnt wraps from 2^FRAME_CNT_W-1 to 0 without affecting scanning.
- ext_hold high:
  - Hold counter, scan_sel, scan_data and state are frozen.
  - scan_strobe and frame_start are forced low.
  - A strobe already issued is not repeated after release.
  - If ext_hold is high when a capture edge would occur, the capture is deferred to the first edge with ext_hold low.
- All outputs are driven directly from registers, with no combinational input-to-output path.

Optional Feature:
- Macro: ARR_SCAN_SKIP_UNCHANGED_EN.
- Defined:
  - At a would-be capture edge with snap_valid=1 and arr0..3 equal to the snapshot, no capture occurs.
  - The block enters S_WAIT and holds scan_data and scan_sel at their slot-3 values. Strobes stay low and frame_cnt does not change.
  - On the first edge in S_WAIT where the inputs differ (and ext_hold is low), a normal capture edge occurs.
  - The first frame after reset always captures.
- Undefined: S_WAIT does not exist, and every frame recaptures unconditionally.

Decomposition:
- Package arr_scan_pkg contains:
  - typedef arr_t (logic [3:0])
  - constant NUM_ARR=4
  - typedef sel_t (logic [1:0])
  - enum scan_state_e {S_IDLE, S_SCAN, S_WAIT}
- Sub-module arr_scan_timer:
  - Function: hold counter plus slot counter.
  - Inputs: enable (=~ext_hold) and a restart signal.
  - Outputs: slot_adv, frame_end, and sel.
- Top level: snapshot registers, output registers and the FSM.

Test Plan:
- HOLD_CYCLES=4. Release reset with arr0..3=1,2,3,4 held: frame_start at cycle 1 after release. scan_sel goes 0,1,2,3 every 4 cycles with scan_data 1,2,3,4. frame_cnt=1, then 2 at cycle 17.
- Change arr1 to 0xF at slot 2 of frame 1: frame 1 still shows 2 in slot 1. Frame 2 shows 0xF in slot 1.
- Assert ext_hold for 3 cycles on the 2nd cycle of slot 1: slot 1 lasts 7 cycles, with exactly one strobe for that slot.
- Hold ext_hold across the capture edge: no frame_start while held. Capture happens on the first edge after release, using the arr values at that edge.
- Assert reset at slot 2: next cycle all outputs are 0. The first capture follows release and frame_cnt restarts at 1.
- With ARR_SCAN_SKIP_UNCHANGED_EN, constant inputs: one frame, then S_WAIT with strobe low and frame_cnt=1. Change arr3: capture on that edge and frame_cnt=2.
